ntt_coef_loader: RTL and testbench

Drains the two input coefficient FIFOs on the NTT read side. Each FIFO word is packed {unused[31:24], addr[23:16], coef[15:0]}. The block unpacks each word pair and drives the dual-port coefficient RAM write ports of the NTT core, checking every address and range. It sits between fifo1/fifo2 (read side) and the NTT core, and signals load completion to the core's start logic.

---
 rtl/ntt_loader_pkg.sv | 17 +
 rtl/ntt_word_check.sv | 49 ++++
 rtl/ntt_coef_loader.sv | 160 ++++++++++++++++
 tb/tb_ntt_coef_loader.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_loader_pkg.sv
// Shared definitions for the NTT coefficient loader: FSM encoding and the
// FIFO word field layout {unused[31:24], addr[23:16], coef[15:0]}.
package ntt_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned ADDR_LSB  = 16;
  localparam int unsigned ADDR_MSB  = 23;
  localparam int unsigned COEF_MSB  = 15;
  localparam int unsigned Q_DEFAULT = 12289;

endpackage

// File: rtl/ntt_word_check.sv
// Unpacks one FIFO word pair and flags address-order and coefficient-range
// violations for pair index k. Purely combinational.
module ntt_word_check
  import ntt_loader_pkg::*;
#(
  parameter int unsigned N  = 256,
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16,
  parameter int unsigned Q  = Q_DEFAULT,
  parameter int unsigned KW = 8
) (
  input  logic [31:0]   word_a,
  input  logic [31:0]   word_b,
  input  logic [KW-1:0] k,
  output logic [AW-1:0] addr_a,
  output logic [AW-1:0] addr_b,
  output logic [DW-1:0] data_a,
  output logic [DW-1:0] data_b,
  output logic          addr_mismatch,
  output logic          range_err
);

  logic [31:0] field_addr_a;
  logic [31:0] field_addr_b;
  logic [31:0] field_coef_a;
  logic [31:0] field_coef_b;
  logic [31:0] exp_a;
  logic [31:0] exp_b;
  logic        unused_hi;

  assign unused_hi = ^{word_a[31:ADDR_MSB+1], word_b[31:ADDR_MSB+1]};

  // The whole 8-bit field is compared, so upper bits beyond AW count as a mismatch.
  always_comb begin
    field_addr_a  = 32'(word_a[ADDR_MSB:ADDR_LSB]);
    field_addr_b  = 32'(word_b[ADDR_MSB:ADDR_LSB]);
    field_coef_a  = 32'(word_a[COEF_MSB:0]);
    field_coef_b  = 32'(word_b[COEF_MSB:0]);
    exp_a         = 32'(k);
    exp_b         = 32'(k) + (N / 2);
    addr_a        = field_addr_a[AW-1:0];
    addr_b        = field_addr_b[AW-1:0];
    data_a        = field_coef_a[DW-1:0];
    data_b        = field_coef_b[DW-1:0];
    addr_mismatch = (field_addr_a != exp_a) || (field_addr_b != exp_b);
    range_err     = (field_coef_a >= Q) || (field_coef_b >= Q);
  end

endmodule

// File: rtl/ntt_coef_loader.sv
// Drains fifo1/fifo2 in lock-step, writes each unpacked word pair to the NTT
// coefficient RAM ports, and reports completion plus sticky check errors.
module ntt_coef_loader
  import ntt_loader_pkg::*;
#(
  parameter int unsigned N  = 256,
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 16,
  parameter int unsigned Q  = Q_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          rd_empty_a,
  input  logic [31:0]   rd_dat_a,
  input  logic          rd_empty_b,
  input  logic [31:0]   rd_dat_b,
  output logic          rd_req,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr_a,
  output logic [DW-1:0] ram_data_a,
  output logic [AW-1:0] ram_addr_b,
  output logic [DW-1:0] ram_data_b,
  output logic          busy,
  output logic          load_done,
  output logic          err_addr,
  output logic          err_range
);

  localparam int unsigned   CW   = $clog2(N / 2) + 1;
  localparam logic [CW-1:0] HALF = CW'(N / 2);

  state_e        state_q, state_d;
  logic [CW-1:0] req_cnt_q, req_cnt_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] k_cur;
  logic          rd_valid_q, rd_valid_d;
  logic          ram_we_q, ram_we_d;
  logic [AW-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DW-1:0] data_a_q, data_a_d, data_b_q, data_b_d;
  logic          err_addr_q, err_addr_d;
  logic          err_range_q, err_range_d;
  logic          rd_req_c;

  logic [AW-1:0] chk_addr_a, chk_addr_b;
  logic [DW-1:0] chk_data_a, chk_data_b;
  logic          chk_mismatch, chk_range;

  // A write may be landing this very cycle, so the pair now on the FIFO
  // outputs is index wr_cnt plus that in-flight write.
  assign k_cur = wr_cnt_q + CW'(ram_we_q);

  ntt_word_check #(
    .N  (N),
    .AW (AW),
    .DW (DW),
    .Q  (Q),
    .KW (CW)
  ) u_check (
    .word_a        (rd_dat_a),
    .word_b        (rd_dat_b),
    .k             (k_cur),
    .addr_a        (chk_addr_a),
    .addr_b        (chk_addr_b),
    .data_a        (chk_data_a),
    .data_b        (chk_data_b),
    .addr_mismatch (chk_mismatch),
    .range_err     (chk_range)
  );

  always_comb begin
    state_d     = state_q;
    req_cnt_d   = req_cnt_q;
    wr_cnt_d    = wr_cnt_q + CW'(ram_we_q);
    rd_req_c    = 1'b0;
    ram_we_d    = rd_valid_q;
    addr_a_d    = addr_a_q;
    addr_b_d    = addr_b_q;
    data_a_d    = data_a_q;
    data_b_d    = data_b_q;
    err_addr_d  = err_addr_q  | (rd_valid_q & chk_mismatch);
    err_range_d = err_range_q | (rd_valid_q & chk_range);

    if (rd_valid_q) begin
      addr_a_d = chk_addr_a;
      addr_b_d = chk_addr_b;
      data_a_d = chk_data_a;
      data_b_d = chk_data_b;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = LOAD;
          req_cnt_d   = '0;
          wr_cnt_d    = '0;
          err_addr_d  = 1'b0;
          err_range_d = 1'b0;
        end
      end
      LOAD: begin
        rd_req_c = !rd_empty_a && !rd_empty_b && (req_cnt_q < HALF);
        if (rd_req_c) begin
          req_cnt_d = req_cnt_q + CW'(1);
        end
        if (req_cnt_d == HALF) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (wr_cnt_d == HALF) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_valid_d = rd_req_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      req_cnt_q   <= '0;
      wr_cnt_q    <= '0;
      rd_valid_q  <= 1'b0;
      ram_we_q    <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      err_addr_q  <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_cnt_q   <= req_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_valid_q  <= rd_valid_d;
      ram_we_q    <= ram_we_d;
      addr_a_q    <= addr_a_d;
      addr_b_q    <= addr_b_d;
      data_a_q    <= data_a_d;
      data_b_q    <= data_b_d;
      err_addr_q  <= err_addr_d;
      err_range_q <= err_range_d;
    end
  end

  assign rd_req     = rd_req_c;
  assign ram_we     = ram_we_q;
  assign ram_addr_a = addr_a_q;
  assign ram_addr_b = addr_b_q;
  assign ram_data_a = data_a_q;
  assign ram_data_b = data_b_q;
  assign busy       = (state_q == LOAD) || (state_q == DRAIN);
  assign load_done  = (state_q == DONE);
  assign err_addr   = err_addr_q;
  assign err_range  = err_range_q;

endmodule

// File: tb/tb_ntt_coef_loader.sv
// Scoreboard bench for ntt_coef_loader: queue-based FIFO models feed the DUT,
// expected RAM writes are queued at stimulus time and checked by a monitor.
module tb_ntt_coef_loader;

  localparam int unsigned HALF = 128;
  localparam int unsigned Q    = 12289;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rd_empty_a, rd_empty_b;
  logic [31:0] rd_dat_a, rd_dat_b;
  logic        rd_req, ram_we, busy, load_done, err_addr, err_range;
  logic [7:0]  ram_addr_a, ram_addr_b;
  logic [15:0] ram_data_a, ram_data_b;

  always #5 clk = ~clk;

  ntt_coef_loader #(
    .N  (256),
    .AW (8),
    .DW (16),
    .Q  (Q)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .rd_empty_a (rd_empty_a),
    .rd_dat_a   (rd_dat_a),
    .rd_empty_b (rd_empty_b),
    .rd_dat_b   (rd_dat_b),
    .rd_req     (rd_req),
    .ram_we     (ram_we),
    .ram_addr_a (ram_addr_a),
    .ram_data_a (ram_data_a),
    .ram_addr_b (ram_addr_b),
    .ram_data_b (ram_data_b),
    .busy       (busy),
    .load_done  (load_done),
    .err_addr   (err_addr),
    .err_range  (err_range)
  );

  typedef struct {
    logic [7:0]  aa;
    logic [15:0] da;
    logic [7:0]  ab;
    logic [15:0] db;
    bit          bad_addr;
    bit          bad_range;
  } wr_t;

  logic [31:0] fifo_a[$];
  logic [31:0] fifo_b[$];
  wr_t         exp_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned start_cyc, first_wr_cyc;
  int unsigned wr_seen  = 0;
  int unsigned pops_b   = 0;
  int unsigned stall_after = 0;
  int unsigned stall_len   = 0;
  int unsigned stall_rem   = 0;
  bit          rand_stall  = 1'b0;
  bit          exp_err_addr  = 1'b0;
  bit          exp_err_range = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference: pair k belongs at A=k, B=k+HALF; any coefficient >= Q is out of range.
  task automatic push_pair(input int unsigned k, input logic [31:0] wa, input logic [31:0] wb);
    wr_t e;
    e.aa        = wa[23:16];
    e.da        = wa[15:0];
    e.ab        = wb[23:16];
    e.db        = wb[15:0];
    e.bad_addr  = (int'(e.aa) != k) || (int'(e.ab) != k + HALF);
    e.bad_range = (int'(e.da) >= Q) || (int'(e.db) >= Q);
    fifo_a.push_back(wa);
    fifo_b.push_back(wb);
    exp_q.push_back(e);
  endtask

  task automatic fill_plain(input int unsigned bad_addr_k, input int unsigned bad_coef_k);
    logic [31:0] wa, wb;
    for (int unsigned k = 0; k < HALF; k++) begin
      wa = {8'h00, 8'(k), 16'(k)};
      wb = {8'h00, 8'(k + HALF), 16'(k + HALF)};
      if (k == bad_addr_k) wb[23:16] = 8'(k);
      if (k == bad_coef_k) wa[15:0] = 16'(Q);
      push_pair(k, wa, wb);
    end
  endtask

  task automatic fill_random();
    logic [31:0] wa, wb;
    for (int unsigned k = 0; k < HALF; k++) begin
      wa[31:24] = 8'($urandom_range(0, 255));
      wb[31:24] = 8'($urandom_range(0, 255));
      wa[23:16] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'(k);
      wb[23:16] = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'(k + HALF);
      wa[15:0]  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(Q, 65535))
                                               : 16'($urandom_range(0, Q - 1));
      wb[15:0]  = ($urandom_range(0, 15) == 0) ? 16'($urandom_range(Q, 65535))
                                               : 16'($urandom_range(0, Q - 1));
      push_pair(k, wa, wb);
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start         = 1'b1;
    start_cyc     = cyc;
    exp_err_addr  = 1'b0;
    exp_err_range = 1'b0;
    wr_seen       = 0;
    pops_b        = 0;
    @(negedge clk);
    start = 1'b0;
    check("err_addr_clear_on_start", err_addr, 0);
    check("err_range_clear_on_start", err_range, 0);
    check("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(output int unsigned off);
    bit ok;
    ok  = 1'b0;
    off = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (load_done) ok = 1'b1;
    end
    if (ok) begin
      off = cyc - start_cyc;
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL load_done_timeout: got no load_done expected within 3000 cycles");
    end
  endtask

  task automatic wait_writes(input int unsigned n);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (wr_seen >= n) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_count_timeout: got %0d writes expected %0d", wr_seen, n);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Non-show-ahead FIFO pair: data appears one cycle after the sampled request.
  initial begin : fifo_model
    bit req;
    rd_dat_a   = '0;
    rd_dat_b   = '0;
    rd_empty_a = 1'b1;
    rd_empty_b = 1'b1;
    forever begin
      @(negedge clk);
      req = rd_req;
      @(posedge clk);
      #1;
      if (req) begin
        if (fifo_a.size() > 0) rd_dat_a = fifo_a.pop_front();
        if (fifo_b.size() > 0) begin
          rd_dat_b = fifo_b.pop_front();
          pops_b++;
          if (pops_b == stall_after) stall_rem = stall_len;
        end
      end
      rd_empty_a = (fifo_a.size() == 0) || (rand_stall && $urandom_range(0, 3) == 0);
      rd_empty_b = (fifo_b.size() == 0) || (stall_rem > 0) ||
                   (rand_stall && $urandom_range(0, 3) == 0);
      if (stall_rem > 0) stall_rem--;
    end
  end

  initial begin : monitor
    wr_t e;
    bit  prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rd_req) check("rd_req_while_empty", {31'b0, rd_empty_a | rd_empty_b}, 0);
      if (ram_we) begin
        check("busy_during_write", busy, 1);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_write: got write addr_a=%0d expected none at cycle %0d",
                   ram_addr_a, cyc);
        end else begin
          e = exp_q.pop_front();
          if (wr_seen == 0) first_wr_cyc = cyc;
          wr_seen++;
          exp_err_addr  = exp_err_addr  | e.bad_addr;
          exp_err_range = exp_err_range | e.bad_range;
          check("ram_addr_a", ram_addr_a, e.aa);
          check("ram_data_a", ram_data_a, e.da);
          check("ram_addr_b", ram_addr_b, e.ab);
          check("ram_data_b", ram_data_b, e.db);
          check("err_addr", err_addr, exp_err_addr);
          check("err_range", err_range, exp_err_range);
        end
      end
      if (load_done && !prev_done) begin
        check("writes_at_done", wr_seen, HALF);
        check("pending_at_done", exp_q.size(), 0);
        check("busy_at_done", busy, 0);
        check("ram_we_at_done", ram_we, 0);
      end
      prev_done = load_done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test expected finish before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int unsigned off;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rd_req", rd_req, 0);
    check("reset_ram_we", ram_we, 0);
    check("reset_busy", busy, 0);
    check("reset_load_done", load_done, 0);
    check("reset_err_addr", err_addr, 0);
    check("reset_err_range", err_range, 0);
    rst = 1'b0;

    // Full load, FIFOs preloaded, no stalls.
    fill_plain(999, 999);
    do_start();
    wait_done(off);
    check("plain_done_latency", off, 131);
    check("plain_first_write_latency", first_wr_cyc - start_cyc, 3);
    check("plain_err_addr", err_addr, 0);
    check("plain_err_range", err_range, 0);

    // fifo2 empty for 10 cycles after pair 40.
    fill_plain(999, 999);
    stall_after = 41;
    stall_len   = 10;
    do_start();
    wait_done(off);
    stall_after = 0;
    check("stall_done_latency", off, 141);

    // Address error at pair 5 and range error at pair 7.
    fill_plain(5, 7);
    do_start();
    wait_done(off);
    check("err_load_done_latency", off, 131);
    check("err_addr_sticky", err_addr, 1);
    check("err_range_sticky", err_range, 1);

    // start pulsed mid-load is ignored; flags from the previous load cleared.
    fill_plain(999, 999);
    do_start();
    wait_writes(20);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(off);
    check("busy_start_done_latency", off, 131);
    check("busy_start_err_addr", err_addr, 0);

    // Reset mid-load, then a fresh load from k=0.
    fill_plain(999, 999);
    do_start();
    wait_writes(60);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rd_req", rd_req, 0);
    check("midrst_ram_we", ram_we, 0);
    check("midrst_busy", busy, 0);
    check("midrst_load_done", load_done, 0);
    check("midrst_ram_addr_a", ram_addr_a, 0);
    check("midrst_ram_data_b", ram_data_b, 0);
    rst = 1'b0;
    fifo_a.delete();
    fifo_b.delete();
    exp_q.delete();
    @(negedge clk);
    fill_plain(999, 999);
    do_start();
    wait_done(off);
    check("after_reset_done_latency", off, 131);

    // Randomized loads with random stalls, junk upper bits and sporadic errors.
    rand_stall = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      fill_random();
      do_start();
      wait_done(off);
    end
    rand_stall = 1'b0;

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
